rf_wb_arbiter: RTL



---
 rtl/rf_wb_arbiter_if.sv | 57 +++++
 rtl/rf_wb_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
// Bundles the writeback handshakes, issue-stage reservation, register-file
// write port and scoreboard of rf_wb_arbiter.
//   slave  : arbiter view (requests in, ready/RF port/busy out)
//   master : environment view (drives requests, observes RF port/busy)
// Optional macro RF_WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data.
interface rf_wb_arbiter_if #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4
);
    logic                hold;
    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;
    logic                reserve_valid;
    logic [ADDR_W-1:0]   reserve_addr;
    logic                rf_write;
    logic [ADDR_W-1:0]   rf_addr3;
    logic [DATA_W-1:0]   rf_data3;
    logic [NUM_REGS-1:0] busy;
    logic                last_grant;
`ifdef RF_WB_FWD_EN
    logic                fwd_valid;
    logic [ADDR_W-1:0]   fwd_addr;
    logic [DATA_W-1:0]   fwd_data;

    modport slave (
        input  hold, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               reserve_valid, reserve_addr,
        output alu_ready, mem_ready, rf_write, rf_addr3, rf_data3, busy, last_grant,
               fwd_valid, fwd_addr, fwd_data
    );
    modport master (
        output hold, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               reserve_valid, reserve_addr,
        input  alu_ready, mem_ready, rf_write, rf_addr3, rf_data3, busy, last_grant,
               fwd_valid, fwd_addr, fwd_data
    );
`else
    modport slave (
        input  hold, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               reserve_valid, reserve_addr,
        output alu_ready, mem_ready, rf_write, rf_addr3, rf_data3, busy, last_grant
    );
    modport master (
        output hold, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               reserve_valid, reserve_addr,
        input  alu_ready, mem_ready, rf_write, rf_addr3, rf_data3, busy, last_grant
    );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single register-file write port between the ALU and load
// writeback requesters with round-robin arbitration, and keeps a busy-bit
// scoreboard per destination register.
// Ports:
//   clk     : clock, all state on posedge
//   reset_n : asynchronous active-low reset
//   bus     : rf_wb_arbiter_if.slave (handshakes, reservation, RF write
//             port, busy scoreboard, last_grant)
// Optional macro RF_WB_FWD_EN: drives fwd_* from the commit-in-progress
// write and shows its register as not busy in the same cycle.
// NUM_REGS must equal 2**ADDR_W.
module rf_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    rf_wb_arbiter_if.slave bus
);
    logic                alu_ready;
    logic                mem_ready;
    logic                alu_xfer;
    logic                mem_xfer;
    logic                rf_write_q;
    logic                rf_write_d;
    logic [ADDR_W-1:0]   rf_addr3_q;
    logic [ADDR_W-1:0]   rf_addr3_d;
    logic [DATA_W-1:0]   rf_data3_q;
    logic [DATA_W-1:0]   rf_data3_d;
    logic                last_grant_q;
    logic                last_grant_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // On a tie the requester opposite the most recent grant wins
    // (last_grant: 1 = ALU, 0 = mem).
    always_comb begin
        alu_ready = ~bus.hold & bus.alu_valid & (~bus.mem_valid | ~last_grant_q);
        mem_ready = ~bus.hold & bus.mem_valid & (~bus.alu_valid | last_grant_q);
    end

    assign alu_xfer = alu_ready;   // ready already implies valid
    assign mem_xfer = mem_ready;

    always_comb begin
        rf_write_d   = alu_xfer | mem_xfer;
        rf_addr3_d   = rf_addr3_q;
        rf_data3_d   = rf_data3_q;
        last_grant_d = last_grant_q;
        if (alu_xfer) begin
            rf_addr3_d   = bus.alu_addr;
            rf_data3_d   = bus.alu_data;
            last_grant_d = 1'b1;
        end else if (mem_xfer) begin
            rf_addr3_d   = bus.mem_addr;
            rf_data3_d   = bus.mem_data;
            last_grant_d = 1'b0;
        end
    end

    // Scoreboard: commit clears, reservation sets; set wins on a collision.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (bus.reserve_valid) set_vec[bus.reserve_addr] = 1'b1;
        if (rf_write_q)        clr_vec[rf_addr3_q]       = 1'b1;
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_q   <= 1'b0;
            rf_addr3_q   <= '0;
            rf_data3_q   <= '0;
            last_grant_q <= 1'b1;
            busy_q       <= '0;
        end else begin
            rf_write_q   <= rf_write_d;
            rf_addr3_q   <= rf_addr3_d;
            rf_data3_q   <= rf_data3_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.mem_ready  = mem_ready;
    assign bus.rf_write   = rf_write_q;
    assign bus.rf_addr3   = rf_addr3_q;
    assign bus.rf_data3   = rf_data3_q;
    assign bus.last_grant = last_grant_q;

`ifdef RF_WB_FWD_EN
    // Bits set by a reservation at the last edge belong to a new pending
    // write, so the commit in progress must not mask them.
    logic [NUM_REGS-1:0] set_last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) set_last_q <= '0;
        else          set_last_q <= set_vec;
    end

    assign bus.busy      = busy_q & ~(clr_vec & ~set_last_q);
    assign bus.fwd_valid = rf_write_q;
    assign bus.fwd_addr  = rf_addr3_q;
    assign bus.fwd_data  = rf_data3_q;
`else
    assign bus.busy = busy_q;
`endif

endmodule
